// File: rtl/mips_cpu_ctrl_fsm_pkg.sv
// ---------------------------------------------------------------------------
// mips_cpu_ctrl_fsm_pkg
//   Shared definitions for the multicycle control path: FSM state encoding,
//   write-back destination select, MIPS opcode / funct field constants and the
//   REGIMM link bit. Also provides a helper that tells whether a write-back
//   would target register $0 and must therefore be suppressed.
// ---------------------------------------------------------------------------
package mips_cpu_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // Register-file destination select; WB_RA forces index 31 in the datapath.
  typedef enum logic [1:0] {
    WB_RT = 2'd0,
    WB_RD = 2'd1,
    WB_RA = 2'd2
  } wb_dst_t;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] funct_t;

  // Primary opcodes
  localparam opcode_t OP_SPECIAL = 6'h00;
  localparam opcode_t OP_REGIMM  = 6'h01;
  localparam opcode_t OP_J       = 6'h02;
  localparam opcode_t OP_JAL     = 6'h03;
  localparam opcode_t OP_BEQ     = 6'h04;
  localparam opcode_t OP_BNE     = 6'h05;
  localparam opcode_t OP_BLEZ    = 6'h06;
  localparam opcode_t OP_BGTZ    = 6'h07;
  localparam opcode_t OP_ADDI    = 6'h08;
  localparam opcode_t OP_ADDIU   = 6'h09;
  localparam opcode_t OP_SLTI    = 6'h0A;
  localparam opcode_t OP_SLTIU   = 6'h0B;
  localparam opcode_t OP_ANDI    = 6'h0C;
  localparam opcode_t OP_ORI     = 6'h0D;
  localparam opcode_t OP_XORI    = 6'h0E;
  localparam opcode_t OP_LUI     = 6'h0F;
  localparam opcode_t OP_LB      = 6'h20;
  localparam opcode_t OP_LH      = 6'h21;
  localparam opcode_t OP_LWL     = 6'h22;
  localparam opcode_t OP_LW      = 6'h23;
  localparam opcode_t OP_LBU     = 6'h24;
  localparam opcode_t OP_LHU     = 6'h25;
  localparam opcode_t OP_LWR     = 6'h26;
  localparam opcode_t OP_SB      = 6'h28;
  localparam opcode_t OP_SH      = 6'h29;
  localparam opcode_t OP_SWL     = 6'h2A;
  localparam opcode_t OP_SW      = 6'h2B;
  localparam opcode_t OP_SWR     = 6'h2E;

  // SPECIAL function codes
  localparam funct_t FUNCT_SLL   = 6'h00;
  localparam funct_t FUNCT_SRL   = 6'h02;
  localparam funct_t FUNCT_SRA   = 6'h03;
  localparam funct_t FUNCT_SLLV  = 6'h04;
  localparam funct_t FUNCT_SRLV  = 6'h06;
  localparam funct_t FUNCT_SRAV  = 6'h07;
  localparam funct_t FUNCT_JR    = 6'h08;
  localparam funct_t FUNCT_JALR  = 6'h09;
  localparam funct_t FUNCT_MFHI  = 6'h10;
  localparam funct_t FUNCT_MTHI  = 6'h11;
  localparam funct_t FUNCT_MFLO  = 6'h12;
  localparam funct_t FUNCT_MTLO  = 6'h13;
  localparam funct_t FUNCT_MULT  = 6'h18;
  localparam funct_t FUNCT_MULTU = 6'h19;
  localparam funct_t FUNCT_DIV   = 6'h1A;
  localparam funct_t FUNCT_DIVU  = 6'h1B;
  localparam funct_t FUNCT_ADD   = 6'h20;
  localparam funct_t FUNCT_ADDU  = 6'h21;
  localparam funct_t FUNCT_SUB   = 6'h22;
  localparam funct_t FUNCT_SUBU  = 6'h23;
  localparam funct_t FUNCT_AND   = 6'h24;
  localparam funct_t FUNCT_OR    = 6'h25;
  localparam funct_t FUNCT_XOR   = 6'h26;
  localparam funct_t FUNCT_NOR   = 6'h27;
  localparam funct_t FUNCT_SLT   = 6'h2A;
  localparam funct_t FUNCT_SLTU  = 6'h2B;

  // REGIMM: rt bit 4 distinguishes the linking branches (BLTZAL 5'h10,
  // BGEZAL 5'h11) from the plain ones (BLTZ 5'h00, BGEZ 5'h01).
  localparam int REGIMM_LINK_BIT = 4;

  // A write-back aimed at $0 still visits S_WB but must not strobe the
  // register file. Link writes always go to $31.
  function automatic logic wb_suppressed(wb_dst_t dst, logic [4:0] rt, logic [4:0] rd);
    return ((dst == WB_RD) && (rd == 5'd0)) || ((dst == WB_RT) && (rt == 5'd0));
  endfunction

endpackage

// File: rtl/mips_cpu_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// mips_cpu_ctrl_fsm_if
//   Avalon-style memory handshake between the control FSM and the memory
//   port of the datapath.
//     mem_read        : read request (instruction fetch or load)
//     mem_write       : write request (store)
//     mem_waitrequest : memory not ready; requester holds its request
//   master modport : control FSM side (drives requests)
//   slave  modport : memory side (drives waitrequest)
// ---------------------------------------------------------------------------
interface mips_cpu_ctrl_fsm_if;
  logic mem_read;
  logic mem_write;
  logic mem_waitrequest;

  modport master (
    output mem_read,
    output mem_write,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    output mem_waitrequest
  );
endinterface

// File: rtl/mips_cpu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// mips_cpu_ctrl_decode
//   Purely combinational instruction classifier for the control FSM.
//   Ports:
//     opcode, funct, rt : instruction fields of the held instruction
//     is_load           : instruction reads data memory
//     is_store          : instruction writes data memory
//     has_wb            : instruction writes the register file
//     wb_dst            : destination select (WB_RT when has_wb=0)
//     is_multdiv        : instruction must wait for the mult/div unit
//   Unknown opcodes/functs decode as a no-op (all flags 0).
// ---------------------------------------------------------------------------
module mips_cpu_ctrl_decode
  import mips_cpu_ctrl_fsm_pkg::*;
(
  input  opcode_t     opcode,
  input  funct_t      funct,
  input  logic [4:0]  rt,
  output logic        is_load,
  output logic        is_store,
  output logic        has_wb,
  output wb_dst_t     wb_dst,
  output logic        is_multdiv
);

  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    has_wb     = 1'b0;
    wb_dst     = WB_RT;
    is_multdiv = 1'b0;

    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV,
          FUNCT_JALR,
          FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_SUBU,
          FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR,
          FUNCT_SLT, FUNCT_SLTU: begin
            has_wb = 1'b1;
            wb_dst = WB_RD;
          end
          // HI/LO reads are ordered behind an in-flight mult/div.
          FUNCT_MFHI, FUNCT_MFLO: begin
            has_wb     = 1'b1;
            wb_dst     = WB_RD;
            is_multdiv = 1'b1;
          end
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            is_multdiv = 1'b1;
          end
          // JR, MTHI, MTLO and unknown functs: no register-file write.
          default: ;
        endcase
      end

      OP_REGIMM: begin
        if (rt[REGIMM_LINK_BIT]) begin
          has_wb = 1'b1;
          wb_dst = WB_RA;
        end
      end

      OP_JAL: begin
        has_wb = 1'b1;
        wb_dst = WB_RA;
      end

      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        has_wb = 1'b1;
        wb_dst = WB_RT;
      end

      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: begin
        is_load = 1'b1;
        has_wb  = 1'b1;
        wb_dst  = WB_RT;
      end

      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: begin
        is_store = 1'b1;
      end

      // J and conditional branches complete in S_EXEC; unknown opcodes too.
      OP_J, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: ;
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_cpu_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mips_cpu_ctrl_fsm
//   Multicycle control FSM. Sequences FETCH -> EXEC -> (MEM) -> (WB) for one
//   instruction at a time and halts when the PC reaches zero.
//   Ports:
//     clk, reset      : clock; synchronous active-high reset
//     opcode, funct   : fields of the held instruction (valid from EXEC)
//     rt, rd          : register fields (REGIMM sub-op / destinations)
//     pc_zero         : current PC is zero -> halt instead of fetching
//     multdiv_busy    : mult/div unit still computing
//     mem             : memory handshake (master side)
//     ir_write        : pulse, latch the fetched instruction word
//     pc_write        : pulse, advance the PC
//     reg_write_en    : one-cycle register-file write strobe
//     reg_dst         : write-back destination select
//     active          : processor running (FETCH..WB)
//   Only the state register is stored; outputs are decodes of the state and
//   the held instruction. ir_write/pc_write additionally wait for the fetch
//   to be accepted (mem_waitrequest low).
// ---------------------------------------------------------------------------
module mips_cpu_ctrl_fsm
  import mips_cpu_ctrl_fsm_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  opcode_t                     opcode,
  input  funct_t                      funct,
  input  logic [4:0]                  rt,
  input  logic [4:0]                  rd,
  input  logic                        pc_zero,
  input  logic                        multdiv_busy,
  mips_cpu_ctrl_fsm_if.master         mem,
  output logic                        ir_write,
  output logic                        pc_write,
  output logic                        reg_write_en,
  output wb_dst_t                     reg_dst,
  output logic                        active
);

  state_t  state;

  logic    is_load;
  logic    is_store;
  logic    has_wb;
  wb_dst_t wb_dst;
  logic    is_multdiv;

  mips_cpu_ctrl_decode u_decode (
    .opcode     (opcode),
    .funct      (funct),
    .rt         (rt),
    .is_load    (is_load),
    .is_store   (is_store),
    .has_wb     (has_wb),
    .wb_dst     (wb_dst),
    .is_multdiv (is_multdiv)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_FETCH;

        // pc_zero takes priority: no fetch request is issued at PC 0.
        S_FETCH: begin
          if (pc_zero)
            state <= S_HALT;
          else if (!mem.mem_waitrequest)
            state <= S_EXEC;
        end

        S_EXEC: begin
          if (is_multdiv && multdiv_busy)
            state <= S_EXEC;
          else if (is_load || is_store)
            state <= S_MEM;
          else if (has_wb)
            state <= S_WB;
          else
            state <= S_FETCH;
        end

        S_MEM: begin
          if (!mem.mem_waitrequest)
            state <= is_load ? S_WB : S_FETCH;
        end

        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_RESET;
      endcase
    end
  end

  logic fetch_req;
  assign fetch_req = (state == S_FETCH) && !pc_zero;

  // Load and store are mutually exclusive in the decoder and FETCH never
  // writes, so read and write can never be asserted together.
  assign mem.mem_read  = fetch_req || ((state == S_MEM) && is_load);
  assign mem.mem_write = (state == S_MEM) && is_store;

  assign ir_write = fetch_req && !mem.mem_waitrequest;
  assign pc_write = fetch_req && !mem.mem_waitrequest;

  assign reg_write_en = (state == S_WB) && !wb_suppressed(wb_dst, rt, rd);

  assign reg_dst = ((state == S_EXEC) || (state == S_MEM) || (state == S_WB)) ? wb_dst : WB_RT;

  assign active = (state == S_FETCH) || (state == S_EXEC) ||
                  (state == S_MEM)   || (state == S_WB);

endmodule
